hour_counter_12h: RTL and testbench

- BCD hour counter for the 12-hour digital clock, 12 -> 01 -> 02 ... 11 -> 12.
- Sits between the minute counter, which supplies min_carry, and the AM/PM stage and display, which consume hour_tens/hour_units.
- Provides a user set mode: manual inc/dec, display blink, optional auto-repeat.

---
 rtl/hour_counter_12h_pkg.sv | 22 ++
 rtl/hour_counter_12h_if.sv | 22 ++
 rtl/hour_counter_12h_btn_step.sv | 70 +++++++
 rtl/hour_counter_12h.sv | 130 +++++++++++++
 tb/tb_hour_counter_12h.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hour_counter_12h_pkg.sv
// Shared types and sizing helpers for the 12-hour clock hour stage.
// Counter widths derive from the cycle counts they must reach.
package clock_pkg;

  typedef enum logic {RUN, SET} state_e;

  localparam logic [7:0] HOUR_MIN = 8'h01;
  localparam logic [7:0] HOUR_MAX = 8'h12;

  localparam int BLINK_CYC_DEF  = 50_000_000;
  localparam int REPEAT_DLY_DEF = 50_000_000;
  localparam int REPEAT_PER_DEF = 10_000_000;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int BLINK_W  = cnt_w(BLINK_CYC_DEF);
  localparam int REPEAT_W = cnt_w(REPEAT_DLY_DEF + 1);

endpackage

// File: rtl/hour_counter_12h_if.sv
// Hour counter signal bundle: minute carry and user controls in, BCD hour and display status out.
interface hour_counter_12h_if;
  logic       min_carry;
  logic       set_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [3:0] hour_tens;
  logic [3:0] hour_units;
  logic       hour_roll;
  logic       in_set;
  logic       blink;

  modport master (
    output min_carry, set_mode, btn_inc, btn_dec,
    input  hour_tens, hour_units, hour_roll, in_set, blink
  );

  modport slave (
    input  min_carry, set_mode, btn_inc, btn_dec,
    output hour_tens, hour_units, hour_roll, in_set, blink
  );
endinterface

// File: rtl/hour_counter_12h_btn_step.sv
// Button rising-edge detector producing a one-cycle step pulse while enabled.
// With HOUR_AUTO_REPEAT_EN, a button held alone repeats after REPEAT_DLY, then every REPEAT_PER.
module btn_step
`ifdef HOUR_AUTO_REPEAT_EN
#(
  parameter int REPEAT_DLY = clock_pkg::REPEAT_DLY_DEF,
  parameter int REPEAT_PER = clock_pkg::REPEAT_PER_DEF
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
`ifdef HOUR_AUTO_REPEAT_EN
  input  logic other_i,
`endif
  input  logic en_i,
  output logic step_o
);

  logic btn_q;
  logic rise;

  assign rise = btn_i & ~btn_q;

`ifdef HOUR_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = clock_pkg::cnt_w(RMAX + 1);

  logic [RW-1:0] cnt_q;
  logic          rpt_q;
  logic          active;
  logic          fire;

  // cnt_q counts cycles since the last step; rpt_q selects the shorter period once repeating.
  assign active = en_i & btn_i & ~other_i;
  assign fire   = active & ~rise & (cnt_q == (rpt_q ? RW'(REPEAT_PER) : RW'(REPEAT_DLY)));
  assign step_o = (en_i & rise) | fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      if (!active) begin
        cnt_q <= '0;
        rpt_q <= 1'b0;
      end else if (rise || fire) begin
        cnt_q <= RW'(1);
        rpt_q <= fire;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  assign step_o = en_i & rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end
`endif

endmodule

// File: rtl/hour_counter_12h.sv
// BCD 12-hour counter (12 -> 01 .. 11 -> 12) with a user SET mode, button stepping and display blink.
// Optional auto-repeat of held buttons is built when HOUR_AUTO_REPEAT_EN is defined.
module hour_counter_12h
  import clock_pkg::*;
#(
  parameter int BLINK_CYC  = BLINK_CYC_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
)
(
  input logic               clk,
  input logic               rst_n,
  hour_counter_12h_if.slave bus
);

  localparam int BW = cnt_w(BLINK_CYC);

  state_e        state_q, state_d;
  logic [7:0]    hour_q, hour_d;
  logic          roll_q, roll_d;
  logic          in_set_q;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          step_en, inc_step, dec_step;

  function automatic logic [7:0] bcd_inc(input logic [7:0] h);
    if (h == HOUR_MAX)        return HOUR_MIN;
    else if (h[3:0] == 4'd9)  return {h[7:4] + 4'd1, 4'd0};
    else                      return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] h);
    if (h == HOUR_MIN)        return HOUR_MAX;
    else if (h[3:0] == 4'd0)  return {h[7:4] - 4'd1, 4'd9};
    else                      return {h[7:4], h[3:0] - 4'd1};
  endfunction

  assign step_en = (state_q == SET);

  btn_step
`ifdef HOUR_AUTO_REPEAT_EN
    #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
  u_inc (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.btn_inc),
`ifdef HOUR_AUTO_REPEAT_EN
    .other_i(bus.btn_dec),
`endif
    .en_i   (step_en),
    .step_o (inc_step)
  );

  btn_step
`ifdef HOUR_AUTO_REPEAT_EN
    #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
  u_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.btn_dec),
`ifdef HOUR_AUTO_REPEAT_EN
    .other_i(bus.btn_inc),
`endif
    .en_i   (step_en),
    .step_o (dec_step)
  );

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    roll_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.min_carry) begin
          hour_d = bcd_inc(hour_q);
          roll_d = (hour_q == HOUR_MAX);
        end
        if (bus.set_mode) state_d = SET;
      end
      SET: begin
        // Opposing steps in the same cycle cancel; min_carry is dropped here.
        if (inc_step && !dec_step)      hour_d = bcd_inc(hour_q);
        else if (dec_step && !inc_step) hour_d = bcd_dec(hour_q);
        if (!bus.set_mode) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (state_q != SET || state_d != SET || inc_step || dec_step) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BW'(BLINK_CYC - 1)) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d  = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      hour_q   <= HOUR_MAX;
      roll_q   <= 1'b0;
      in_set_q <= 1'b0;
      blink_q  <= 1'b1;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      roll_q   <= roll_d;
      in_set_q <= (state_d == SET);
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign bus.hour_tens  = hour_q[7:4];
  assign bus.hour_units = hour_q[3:0];
  assign bus.hour_roll  = roll_q;
  assign bus.in_set     = in_set_q;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_hour_counter_12h.sv
// Directed bench for hour_counter_12h with small blink/repeat parameters and a queue of expected outputs.
module tb_hour_counter_12h;

  typedef struct {
    int    hour;
    bit    roll;
    bit    ins;
    bit    bl;
    string tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   h;
  exp_t q[$];

  hour_counter_12h_if bus();

  hour_counter_12h #(.BLINK_CYC(4), .REPEAT_DLY(10), .REPEAT_PER(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hinc(input int x);
    return (x == 12) ? 1 : x + 1;
  endfunction

  function automatic int hdec(input int x);
    return (x == 1) ? 12 : x - 1;
  endfunction

  task automatic drive(input bit mc, input bit sm, input bit bi, input bit bd);
    bus.min_carry = mc;
    bus.set_mode  = sm;
    bus.btn_inc   = bi;
    bus.btn_dec   = bd;
  endtask

  task automatic push(input int eh, input bit er, input bit ei, input bit eb, input string tag);
    exp_t e;
    e.hour = eh; e.roll = er; e.ins = ei; e.bl = eb; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [10:0] obs;
    logic [10:0] expv;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e    = q.pop_front();
      obs  = {bus.hour_tens, bus.hour_units, bus.hour_roll, bus.in_set, bus.blink};
      expv = {4'(e.hour / 10), 4'(e.hour % 10), e.roll, e.ins, e.bl};
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h (tens,units,roll,in_set,blink)", e.tag, obs, expv);
      end
    end
  endtask

  // Drive for one clock, then compare the outputs that edge produced.
  task automatic cyc(input bit mc, input bit sm, input bit bi, input bit bd,
                     input int eh, input bit er, input bit ei, input bit eb, input string tag);
    drive(mc, sm, bi, bd);
    push(eh, er, ei, eb, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic now_chk(input int eh, input bit er, input bit ei, input bit eb, input string tag);
    push(eh, er, ei, eb, tag);
    pop_check();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    now_chk(12, 0, 0, 1, "reset_state");
    rst_n = 1'b1;

    // First carry: digits hold 12 during the carry cycle, then 01 with a single roll pulse.
    drive(1, 0, 0, 0);
    now_chk(12, 0, 0, 1, "digits_during_carry");
    cyc(1, 0, 0, 0, 1, 1, 0, 1, "carry_12_to_01");
    cyc(0, 0, 0, 0, 1, 0, 0, 1, "roll_one_cycle");
    h = 1;

    // 01 -> 09 -> 10 -> 12 -> 01, each carry followed by an idle cycle.
    for (int i = 0; i < 12; i++) begin
      int p;
      p = h;
      h = hinc(h);
      cyc(1, 0, 0, 0, h, (p == 12), 0, 1, "run_carry");
      cyc(0, 0, 0, 0, h, 0, 0, 1, "run_idle");
    end
    for (int i = 0; i < 4; i++) begin
      h = hinc(h);
      cyc(1, 0, 0, 0, h, 0, 0, 1, "to_05");
    end

    // Enter SET at 05; blink runs 1111 0000 1111 0 with BLINK_CYC=4.
    cyc(0, 1, 0, 0, 5, 0, 1, 1, "enter_set");
    for (int k = 1; k <= 12; k++)
      cyc(0, 1, 0, 0, 5, 0, 1, ((k / 4) % 2) == 0, "blink_pattern");

    // Press during blink=0 restarts the blink phase.
    h = hinc(h);
    cyc(0, 1, 1, 0, h, 0, 1, 1, "step_forces_blink");
    for (int k = 1; k <= 4; k++)
      cyc(0, 1, 0, 0, h, 0, 1, (k < 4), "blink_restart");

    for (int i = 0; i < 2; i++) begin
      h = hinc(h);
      cyc(0, 1, 1, 0, h, 0, 1, 1, "inc_press");
      cyc(0, 1, 0, 0, h, 0, 1, 1, "inc_release");
    end
    for (int i = 0; i < 8; i++) begin
      h = hdec(h);
      cyc(0, 1, 0, 1, h, 0, 1, 1, "dec_press");
      cyc(0, 1, 0, 0, h, 0, 1, 1, "dec_release");
    end

    // min_carry in SET is dropped, even at 12 where RUN would roll.
    cyc(1, 1, 0, 0, 12, 0, 1, 1, "set_carry_12");
    cyc(0, 1, 0, 0, 12, 0, 1, 1, "set_carry_idle");
    h = 1;
    cyc(0, 1, 1, 0, h, 0, 1, 1, "inc_12_to_01");
    cyc(0, 1, 0, 0, h, 0, 1, 1, "inc_release2");
    cyc(1, 1, 0, 0, h, 0, 1, 1, "set_carry_01");
    cyc(0, 1, 0, 0, h, 0, 1, 1, "set_carry_idle2");
    h = 2;
    cyc(0, 1, 1, 0, h, 0, 1, 1, "inc_01_to_02");
    cyc(0, 1, 0, 0, h, 0, 1, 1, "inc_release3");
    cyc(0, 1, 1, 1, h, 0, 1, 1, "inc_dec_same_cycle");
    cyc(0, 1, 0, 0, h, 0, 1, 1, "both_release");

    // Button already high before SET entry must not step.
    cyc(0, 0, 0, 0, h, 0, 0, 1, "exit_set");
    cyc(0, 0, 1, 0, h, 0, 0, 1, "btn_ignored_in_run");
    cyc(0, 1, 1, 0, h, 0, 1, 1, "enter_with_held_btn");
    cyc(0, 1, 1, 0, h, 0, 1, 1, "held_no_step");
    cyc(0, 1, 0, 0, h, 0, 1, 1, "held_release");

    // Reset while in SET returns to RUN at 12.
    #2;
    rst_n = 1'b0;
    #1;
    now_chk(12, 0, 0, 1, "reset_mid_set");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    h = 12;
    cyc(0, 0, 0, 0, h, 0, 0, 1, "after_reset_idle");

`ifdef HOUR_AUTO_REPEAT_EN
    for (int i = 0; i < 11; i++) begin
      int p;
      p = h;
      h = hinc(h);
      cyc(1, 0, 0, 0, h, (p == 12), 0, 1, "to_11");
    end
    cyc(0, 1, 0, 0, h, 0, 1, 1, "enter_set_rpt");
    begin
      int last;
      last = 0;
      for (int k = 0; k < 19; k++) begin
        if (k == 0 || k == 10 || k == 13 || k == 16) begin
          h = hinc(h);
          last = k;
        end
        cyc(0, 1, 1, 0, h, 0, 1, (((k - last) / 4) % 2) == 0, "auto_repeat_hold");
      end
    end
    rst_n = 1'b0;
    #1;
    now_chk(12, 0, 0, 1, "reset_mid_hold");
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 12, 0, 0, 1, "after_hold_reset");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
